// File: rtl/ad7928_responder_if.sv
// ad7928_responder_if: SPI lines between an AD7928-style master and the responder.
interface ad7928_responder_if;
  logic spi_sclk;
  logic spi_csn;
  logic spi_din;
  logic spi_dout;
  modport master (output spi_sclk, spi_csn, spi_din, input spi_dout);
  modport slave (input spi_sclk, spi_csn, spi_din, output spi_dout);
endinterface

// File: rtl/ad7928_responder.sv
// ad7928_responder: emulates an AD7928 ADC on SPI, returning channel samples and latching control writes.
module ad7928_responder (
  input  logic                 Clock_in,
  input  logic                 rstn,
  ad7928_responder_if.slave    spi,
  input  logic [95:0]          chan_data,
  output logic [11:0]          ctrl_reg,
  output logic                 ctrl_valid,
  output logic                 frame_err
);
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, SHIFT = 2'd2;
  logic [1:0] state, sclk_s, csn_s, din_s, warm;
  logic sclk_d, dout;
  logic [14:0] tx;
  logic [11:0] rx;
  logic [4:0] bit_cnt;
  logic [2:0] cur_addr;
  logic [7:0][11:0] ch;
  logic csn, sclk_fall;
  assign ch = chan_data;
  assign csn = csn_s[1];
  assign sclk_fall = sclk_d & ~sclk_s[1];
  assign spi.spi_dout = dout;
  // warm keeps IDLE from trusting the reset-preloaded csn synchronizer until it has seen the real pin
  always_ff @(posedge Clock_in or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      sclk_s <= 2'b11;
      csn_s <= 2'b11;
      din_s <= 2'b00;
      warm <= 2'b00;
      sclk_d <= 1'b1;
      dout <= 1'b0;
      tx <= '0;
      rx <= '0;
      bit_cnt <= '0;
      cur_addr <= '0;
      ctrl_reg <= '0;
      ctrl_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], spi.spi_sclk};
      csn_s <= {csn_s[0], spi.spi_csn};
      din_s <= {din_s[0], spi.spi_din};
      warm <= {warm[0], 1'b1};
      sclk_d <= sclk_s[1];
      ctrl_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (warm[1] && csn) state <= ARMED;
        ARMED: if (!csn) begin
          state <= SHIFT;
          tx <= {cur_addr, ch[cur_addr]};
          bit_cnt <= '0;
          dout <= 1'b0;
        end
        SHIFT: if (csn) begin
          state <= ARMED;
          dout <= 1'b0;
          if (bit_cnt == 5'd16) begin
            if (rx[11]) begin
              ctrl_reg <= rx;
              cur_addr <= rx[8:6];
              ctrl_valid <= 1'b1;
            end
          end else frame_err <= 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt < 5'd16) begin
            if (bit_cnt < 5'd12) rx <= {rx[10:0], din_s[1]};
            tx <= {tx[13:0], 1'b0};
            dout <= tx[14];
            bit_cnt <= bit_cnt + 5'd1;
          end else bit_cnt <= 5'd17;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ad7928_responder.sv
// tb_ad7928_responder: directed and random SPI frames checked against a frame-level model.
module tb_ad7928_responder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [95:0] chan_data;
  logic [11:0] ctrl_reg;
  logic ctrl_valid, frame_err;
  int total = 0, bad = 0, nvalid = 0, nerr = 0;
  logic [11:0] m_ctrl = '0;
  logic [2:0] m_addr = '0;
  ad7928_responder_if spi ();
  ad7928_responder dut (
    .Clock_in(clk),
    .rstn(rstn),
    .spi(spi),
    .chan_data(chan_data),
    .ctrl_reg(ctrl_reg),
    .ctrl_valid(ctrl_valid),
    .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ctrl_valid) nvalid <= nvalid + 1;
    if (frame_err) nerr <= nerr + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [11:0] sample(input int a);
    return chan_data[a*12 +: 12];
  endfunction
  // One frame of n SCLK falling edges; DOUT is sampled late in each high phase.
  task automatic frame(input logic [15:0] din, input int n, input int hp);
    logic [15:0] obs, exp;
    logic over;
    int v0, e0, m;
    obs = '0;
    over = 1'b0;
    exp = {1'b0, m_addr, sample(int'(m_addr))};
    v0 = nvalid;
    e0 = nerr;
    spi.spi_csn = 1'b0;
    cyc(6);
    for (int k = 0; k < n; k++) begin
      spi.spi_din = (k < 16) ? din[15-k] : 1'b0;
      cyc(hp);
      if (k < 16) obs[15-k] = spi.spi_dout;
      else over |= spi.spi_dout;
      spi.spi_sclk = 1'b0;
      cyc(hp);
      spi.spi_sclk = 1'b1;
    end
    cyc(hp);
    if (n >= 16) over |= spi.spi_dout;
    spi.spi_csn = 1'b1;
    cyc(8);
    m = (n < 16) ? n : 16;
    chk("dout", 32'(obs >> (16 - m)), 32'(exp >> (16 - m)));
    if (n >= 16) chk("dout_tail", 32'(over), 32'd0);
    if (n == 16 && din[15]) begin
      m_ctrl = din[15:4];
      m_addr = din[12:10];
    end
    chk("valid_cnt", 32'(nvalid - v0), 32'(n == 16 && din[15]));
    chk("err_cnt", 32'(nerr - e0), 32'(n != 16));
    chk("ctrl_reg", 32'(ctrl_reg), 32'(m_ctrl));
    cyc(4);
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1, "timeout");
  end
  initial begin
    int v0, e0;
    spi.spi_sclk = 1'b1;
    spi.spi_csn = 1'b1;
    spi.spi_din = 1'b0;
    chan_data = '0;
    chan_data[11:0] = 12'hABC;
    cyc(3);
    chk("rst_dout", 32'(spi.spi_dout), 32'd0);
    chk("rst_ctrl", 32'(ctrl_reg), 32'd0);
    chk("rst_pulses", 32'({ctrl_valid, frame_err}), 32'd0);
    rstn = 1'b1;
    cyc(4);
    frame({12'h800, 4'h0}, 16, 4);
    chan_data[47:36] = 12'h123;
    frame({12'b100_011_000000, 4'h0}, 16, 4);
    frame(16'h0000, 16, 4);
    frame({12'b000_101_000000, 4'hF}, 16, 4);
    frame(16'h0000, 16, 5);
    frame({12'b110_010_101010, 4'h0}, 10, 4);
    frame({12'b101_110_010101, 4'h0}, 18, 4);
    v0 = nvalid;
    e0 = nerr;
    for (int k = 0; k < 10; k++) begin
      spi.spi_sclk = 1'b0;
      cyc(4);
      spi.spi_sclk = 1'b1;
      cyc(4);
    end
    chk("idle_sclk_pulses", 32'((nvalid - v0) + (nerr - e0)), 32'd0);
    frame({12'b100_111_001100, 4'h3}, 16, 4);
    spi.spi_csn = 1'b0;
    cyc(6);
    for (int k = 0; k < 7; k++) begin
      spi.spi_din = 1'b1;
      cyc(4);
      spi.spi_sclk = 1'b0;
      cyc(4);
      spi.spi_sclk = 1'b1;
    end
    v0 = nvalid;
    e0 = nerr;
    rstn = 1'b0;
    cyc(2);
    chk("midrst_dout", 32'(spi.spi_dout), 32'd0);
    chk("midrst_ctrl", 32'(ctrl_reg), 32'd0);
    rstn = 1'b1;
    m_ctrl = '0;
    m_addr = '0;
    for (int k = 0; k < 6; k++) begin
      cyc(4);
      chk("midrst_dout_hold", 32'(spi.spi_dout), 32'd0);
      spi.spi_sclk = 1'b0;
      cyc(4);
      spi.spi_sclk = 1'b1;
    end
    spi.spi_csn = 1'b1;
    cyc(8);
    chk("midrst_pulses", 32'((nvalid - v0) + (nerr - e0)), 32'd0);
    frame({12'b100_010_000011, 4'h0}, 16, 4);
    for (int r = 0; r < 25; r++) begin
      for (int c = 0; c < 3; c++) chan_data[c*32 +: 32] = $urandom;
      frame(16'($urandom), ($urandom % 4 == 0) ? int'($urandom_range(4, 19)) : 16, int'($urandom_range(4, 6)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
